param_piso_serializer: RTL
==========================

Name: param_piso_serializer

Overview:
- Parametrised parallel-in/serial-out shifter; next generation of the 8-bit encoder PISO.
- Accepts WIDTH-bit words over a valid/ready handshake.
- Serialises each word one bit per clock, in selectable bit order. A one-entry holding buffer lets frames run back-to-back with no idle cycle.
- Feeds the serial encoder/line stage. Replaces the fixed "load every eighth cycle" counter scheme.

Parameters:
- WIDTH, 8: word width in bits; legal range 2..64; elaboration error outside this range.
- LSB_FIRST, 1: 1 = bit 0 sent first; 0 = bit WIDTH-1 sent first.
- IDLE_LEVEL, 0: value driven on serial_out when no bit is valid.

Ports:
- clock  input  1  system clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- message  input  WIDTH  parallel word to send.
- load_valid  input  1  message is valid this cycle.
- load_ready  output  1  block can accept a word this cycle.
- serial_out  output  1  serial data bit (registered).
- serial_valid  output  1  serial_out carries a frame bit (registered).
- frame_start  output  1  one-cycle pulse coincident with the first bit of each frame.
- busy  output  1  high while in SHIFT or the holding buffer is full.

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - state = IDLE; shift register and holding buffer are cleared and the buffered word is discarded.
  - Output values: serial_out = IDLE_LEVEL, serial_valid = 0, frame_start = 0, busy = 0, load_ready = 1.
  - No partial frame resumes after reset is released.
- Handshake:
  - Transfer occurs on a rising edge with load_valid = 1 and load_ready = 1.
  - load_ready = ~hold_full (combinational from a register); it never depends on load_valid.
  - message is sampled only on a transfer edge.
- Internal state: shift register sreg[WIDTH-1:0]; remaining-bit counter rem, width clog2(WIDTH); hold_full flag; 2-state FSM {IDLE, SHIFT}.
- IDLE:
  - Invariant: hold_full = 0.
  - On a transfer edge, the word goes directly to the shifter:
    - serial_out <= first bit;
    - sreg <= word shifted by one toward the remaining bits;
    - rem <= WIDTH-1; serial_valid <= 1; frame_start <= 1; state <= SHIFT.
  - Latency: the first bit is visible in the cycle after acceptance.
- SHIFT, rem != 0:
  - Each edge: serial_out <= next bit; rem <= rem-1; frame_start <= 0.
- SHIFT, rem == 0 (the last bit is on the line); at the next edge:
  - If hold_full: load the held word exactly as in IDLE (frame_start <= 1); hold_full <= 0.
  - Else, if a transfer happens this same edge: load the incoming word directly; hold_full stays 0.
  - Else: serial_out <= IDLE_LEVEL; serial_valid <= 0; frame_start <= 0; state <= IDLE.
- Holding buffer:
  - A transfer while in SHIFT with hold_full = 0 stores the word and sets hold_full <= 1, except in the direct-load case above.
  - While hold_full = 1, load_ready = 0.
  - Transfer and hold-drain never coincide, because load_ready = 0 whenever hold_full = 1.
- Bit order:
  - LSB_FIRST = 1: bits 0..WIDTH-1.
  - LSB_FIRST = 0: bits WIDTH-1..0.
  - Vacated sreg positions fill with 0.
- Throughput: continuous load_valid yields an unbroken serial_valid stream; one word is accepted per WIDTH cycles once the buffer fills.
- busy = (state == SHIFT) | hold_full.
- Boundary conditions:
  - load_valid held high while load_ready = 0 has no effect.
  - message changing while not handshaken is ignored.

Test Plan:
- Single frame, WIDTH = 8, LSB_FIRST = 1:
  - Stimulus: after reset, transfer 8'hA5 at edge T.
  - Required: serial_out = 1,0,1,0,0,1,0,1 in cycles T+1..T+8.
  - serial_valid = 1 for exactly those 8 cycles; frame_start only at T+1.
  - serial_out = 0 and busy = 0 from T+9.
- Back-to-back frames:
  - Stimulus: transfer 8'hA5 at T, then 8'h3C at T+1 (the 3C transfer goes to the hold buffer).
  - Required: load_ready = 0 during T+2..T+8.
  - 16 consecutive valid bits: A5 LSB-first, then 0,0,1,1,1,1,0,0.
  - frame_start at T+1 and T+9; load_ready returns to 1 at T+9.
- Backpressure:
  - Stimulus: load_valid held high with words 1, 2, 3.
  - Required: word 3 is accepted only at the edge following word 1's drain; no word is lost or duplicated.
  - serial_valid stays unbroken for 24 cycles.
- MSB-first, WIDTH = 12, LSB_FIRST = 0:
  - Stimulus: send 12'hF01.
  - Required: output 1,1,1,1,0,0,0,0,0,0,0,1; frame_start on the first bit.
- Direct load at frame end:
  - Stimulus: transfer a word exactly on the edge where rem == 0 and hold is empty.
  - Required: next frame starts with no gap; hold_full stays 0.
- Reset mid-frame, IDLE_LEVEL = 1:
  - Stimulus: assert reset asynchronously at bit 3 of a frame with a word also held.
  - Required: serial_out = 1, serial_valid = 0, busy = 0 immediately.
  - After release, serial_valid = 0 until a new transfer occurs.

Source files
------------

// File: rtl/param_piso_serializer_if.sv
// Word-load and serial-line signal bundle for param_piso_serializer.
//   message      : WIDTH-bit parallel word offered by the producer
//   load_valid   : message is valid this cycle
//   load_ready   : serializer can take a word this cycle
//   serial_out   : registered serial data bit
//   serial_valid : serial_out carries a frame bit
//   frame_start  : pulse on the first bit of each frame
//   busy         : shifting, or a word is waiting in the holding buffer
// master = word producer / line consumer, slave = serializer.
interface param_piso_serializer_if #(
  parameter int unsigned WIDTH = 8
);
  logic [WIDTH-1:0] message;
  logic             load_valid;
  logic             load_ready;
  logic             serial_out;
  logic             serial_valid;
  logic             frame_start;
  logic             busy;

  modport master (
    output message, load_valid,
    input  load_ready, serial_out, serial_valid, frame_start, busy
  );

  modport slave (
    input  message, load_valid,
    output load_ready, serial_out, serial_valid, frame_start, busy
  );
endinterface

// File: rtl/param_piso_serializer.sv
// Parametrised parallel-in/serial-out serializer.
// Accepts WIDTH-bit words over a valid/ready handshake and sends each one
// bit per clock, LSB or MSB first. A one-word holding buffer lets the next
// frame start on the clock right after the previous last bit.
// Ports:
//   clock : system clock, rising edge
//   reset : asynchronous, active-high; discards any frame and held word
//   bus   : param_piso_serializer_if.slave (message/load_valid in,
//           load_ready/serial_out/serial_valid/frame_start/busy out)
// Parameters:
//   WIDTH      : word width, 2..64
//   LSB_FIRST  : 1 = bit 0 first, 0 = bit WIDTH-1 first
//   IDLE_LEVEL : serial_out level while no frame bit is on the line
module param_piso_serializer #(
  parameter int unsigned WIDTH      = 8,
  parameter bit          LSB_FIRST  = 1'b1,
  parameter bit          IDLE_LEVEL = 1'b0
) (
  input  logic                   clock,
  input  logic                   reset,
  param_piso_serializer_if.slave bus
);

  localparam int unsigned REM_W = (WIDTH < 2) ? 1 : $clog2(WIDTH);

  if (WIDTH < 2 || WIDTH > 64) begin : g_width_check
    $error("param_piso_serializer: WIDTH must be within 2..64");
  end

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sreg_q, sreg_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]   hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic               sout_q, sout_d;
  logic               svalid_q, svalid_d;
  logic               fstart_q, fstart_d;

  logic               xfer;
  logic               do_load;
  logic [WIDTH-1:0]   load_word;

  // Bit that leaves the word first in the chosen order.
  function automatic logic lead_bit(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? w[0] : w[WIDTH-1];
  endfunction

  // Move the remaining bits toward the lead position, zero fill behind.
  function automatic logic [WIDTH-1:0] advance(input logic [WIDTH-1:0] w);
    return LSB_FIRST ? (w >> 1) : (w << 1);
  endfunction

  assign xfer = bus.load_valid & ~hold_full_q;

  // State and datapath registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      sreg_q      <= '0;
      rem_q       <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      sout_q      <= IDLE_LEVEL;
      svalid_q    <= 1'b0;
      fstart_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      sreg_q      <= sreg_d;
      rem_q       <= rem_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      sout_q      <= sout_d;
      svalid_q    <= svalid_d;
      fstart_q    <= fstart_d;
    end
  end

  // Next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (xfer) state_d = SHIFT;
      SHIFT:   if (rem_q == '0 && !hold_full_q && !xfer) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Datapath and registered-output next values
  always_comb begin
    sreg_d      = sreg_q;
    rem_d       = rem_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    sout_d      = sout_q;
    svalid_d    = svalid_q;
    fstart_d    = 1'b0;
    do_load     = 1'b0;
    load_word   = '0;

    case (state_q)
      IDLE: begin
        if (xfer) begin
          do_load   = 1'b1;
          load_word = bus.message;
        end
      end
      SHIFT: begin
        if (rem_q != '0) begin
          sout_d = lead_bit(sreg_q);
          sreg_d = advance(sreg_q);
          rem_d  = rem_q - 1'b1;
          if (xfer) begin
            hold_d      = bus.message;
            hold_full_d = 1'b1;
          end
        end else if (hold_full_q) begin
          // load_ready is low here, so no new transfer can collide with the drain
          do_load     = 1'b1;
          load_word   = hold_q;
          hold_full_d = 1'b0;
        end else if (xfer) begin
          // Word arriving on the last-bit edge bypasses the holding buffer
          do_load   = 1'b1;
          load_word = bus.message;
        end else begin
          sout_d   = IDLE_LEVEL;
          svalid_d = 1'b0;
        end
      end
      default: ;
    endcase

    if (do_load) begin
      sout_d   = lead_bit(load_word);
      sreg_d   = advance(load_word);
      rem_d    = REM_W'(WIDTH - 1);
      svalid_d = 1'b1;
      fstart_d = 1'b1;
    end
  end

  assign bus.load_ready   = ~hold_full_q;
  assign bus.busy         = (state_q == SHIFT) | hold_full_q;
  assign bus.serial_out   = sout_q;
  assign bus.serial_valid = svalid_q;
  assign bus.frame_start  = fstart_q;

endmodule
